// File: rtl/program_loader_pkg.sv
// Shared constants and types for the byte-stream program loader and its command decoder.
package program_loader_pkg;

  localparam logic [7:0] TAG_CMD  = 8'hC0;
  localparam logic [7:0] TAG_DATA = 8'hD0;
  localparam logic [7:0] TAG_END  = 8'hE0;

  localparam logic [15:0] CMD_BITS  = 16'd24;
  localparam logic [15:0] DATA_BITS = 16'd16;
  localparam logic [16:0] MEM_BITS  = 17'd1025;

  localparam logic [7:0] OP_00 = 8'h00;
  localparam logic [7:0] OP_11 = 8'h11;
  localparam logic [7:0] OP_15 = 8'h15;
  localparam logic [7:0] OP_21 = 8'h21;
  localparam logic [7:0] OP_25 = 8'h25;
  localparam logic [7:0] OP_31 = 8'h31;
  localparam logic [7:0] OP_F0 = 8'hF0;
  localparam logic [7:0] OP_FE = 8'hFE;
  localparam logic [7:0] OP_FF = 8'hFF;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_CMD0,
    ST_CMD1,
    ST_CMD2,
    ST_DADR0,
    ST_DADR1,
    ST_DDAT0,
    ST_DDAT1,
    ST_WRITE,
    ST_DONE,
    ST_ERROR
  } state_t;

  // Evaluated in 17 bits so an address near 16'hFFFF cannot wrap into range.
  function automatic logic fits_in_mem(input logic [15:0] addr, input logic [15:0] width);
    logic [16:0] last_bit;
    last_bit = {1'b0, addr} + {1'b0, width} - 17'd1;
    return last_bit <= (MEM_BITS - 17'd1);
  endfunction

endpackage

// File: rtl/program_loader_assembler.sv
// Byte shift register; exposes the fields including the byte being accepted this cycle.
module loader_assembler (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        shift_en,
  input  logic [7:0]  in_byte,
  output logic [23:0] cmd_word,
  output logic [15:0] data_addr,
  output logic [15:0] data_word
);

  logic [3:0][7:0] shift_q;
  logic [3:0][7:0] shift_d;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      if (gi == 0) begin : g_head
        assign shift_d[gi] = shift_en ? in_byte : shift_q[gi];
      end else begin : g_body
        assign shift_d[gi] = shift_en ? shift_q[gi-1] : shift_q[gi];
      end
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_q <= '0;
    end else begin
      shift_q <= shift_d;
    end
  end

  assign cmd_word  = {shift_d[2], shift_d[1], shift_d[0]};
  assign data_addr = {shift_d[3], shift_d[2]};
  assign data_word = {shift_d[1], shift_d[0]};

endmodule

// File: rtl/program_loader.sv
// Program loader: parses tagged byte records and writes commands/data into instruction memory.
module program_loader
  import program_loader_pkg::*;
(
  input  logic        clock,
  input  logic        resetN,
  input  logic [7:0]  inByte,
  input  logic        inValid,
  output logic        inReady,
  output logic        memWrite,
  output logic [15:0] memAddress,
  output logic [23:0] memData,
  output logic        memWide,
  output logic        run,
  output logic        error,
  output logic [15:0] cmdCount
);

  state_t      state_q, state_d;
  logic        in_ready_q, in_ready_d;
  logic        mem_write_q, mem_write_d;
  logic [15:0] mem_address_q, mem_address_d;
  logic [23:0] mem_data_q, mem_data_d;
  logic        mem_wide_q, mem_wide_d;
  logic        run_q, run_d;
  logic        error_q, error_d;
  logic [15:0] cmd_count_q, cmd_count_d;

  logic        accept;
  logic [23:0] cmd_word;
  logic [15:0] data_addr;
  logic [15:0] data_word;
  logic [15:0] cmd_addr;

  assign accept   = inValid && in_ready_q;
  assign cmd_addr = cmd_count_q * CMD_BITS;

  loader_assembler u_assembler (
    .clk       (clock),
    .rst_n     (resetN),
    .shift_en  (accept && (state_q != ST_IDLE)),
    .in_byte   (inByte),
    .cmd_word  (cmd_word),
    .data_addr (data_addr),
    .data_word (data_word)
  );

  always_comb begin
    state_d       = state_q;
    in_ready_d    = in_ready_q;
    mem_write_d   = 1'b0;
    mem_address_d = mem_address_q;
    mem_data_d    = mem_data_q;
    mem_wide_d    = mem_wide_q;
    run_d         = run_q;
    error_d       = error_q;
    cmd_count_d   = cmd_count_q;
    case (state_q)
      ST_IDLE: if (accept) begin
        if (inByte == TAG_CMD) begin
          state_d = ST_CMD0;
        end else if (inByte == TAG_DATA) begin
          state_d = ST_DADR0;
        end else if (inByte == TAG_END) begin
          state_d    = ST_DONE;
          run_d      = 1'b1;
          in_ready_d = 1'b0;
        end else begin
          state_d    = ST_ERROR;
          error_d    = 1'b1;
          in_ready_d = 1'b0;
        end
      end
      ST_CMD0:  if (accept) state_d = ST_CMD1;
      ST_CMD1:  if (accept) state_d = ST_CMD2;
      ST_DADR0: if (accept) state_d = ST_DADR1;
      ST_DADR1: if (accept) state_d = ST_DDAT0;
      ST_DDAT0: if (accept) state_d = ST_DDAT1;
      // Range check happens on the last byte so a faulting record never strobes.
      ST_CMD2: if (accept) begin
        in_ready_d = 1'b0;
        if (fits_in_mem(cmd_addr, CMD_BITS)) begin
          state_d       = ST_WRITE;
          mem_write_d   = 1'b1;
          mem_address_d = cmd_addr;
          mem_data_d    = cmd_word;
          mem_wide_d    = 1'b1;
          cmd_count_d   = cmd_count_q + 16'd1;
        end else begin
          state_d = ST_ERROR;
          error_d = 1'b1;
        end
      end
      ST_DDAT1: if (accept) begin
        in_ready_d = 1'b0;
        if (fits_in_mem(data_addr, DATA_BITS)) begin
          state_d       = ST_WRITE;
          mem_write_d   = 1'b1;
          mem_address_d = data_addr;
          mem_data_d    = {data_word, 8'h00};
          mem_wide_d    = 1'b0;
        end else begin
          state_d = ST_ERROR;
          error_d = 1'b1;
        end
      end
      ST_WRITE: begin
        state_d    = ST_IDLE;
        in_ready_d = 1'b1;
      end
      ST_DONE, ST_ERROR: ;
      default: begin
        state_d    = ST_ERROR;
        error_d    = 1'b1;
        run_d      = 1'b0;
        in_ready_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      state_q       <= ST_IDLE;
      in_ready_q    <= 1'b1;
      mem_write_q   <= 1'b0;
      mem_address_q <= '0;
      mem_data_q    <= '0;
      mem_wide_q    <= 1'b0;
      run_q         <= 1'b0;
      error_q       <= 1'b0;
      cmd_count_q   <= '0;
    end else begin
      state_q       <= state_d;
      in_ready_q    <= in_ready_d;
      mem_write_q   <= mem_write_d;
      mem_address_q <= mem_address_d;
      mem_data_q    <= mem_data_d;
      mem_wide_q    <= mem_wide_d;
      run_q         <= run_d;
      error_q       <= error_d;
      cmd_count_q   <= cmd_count_d;
    end
  end

  assign inReady    = in_ready_q;
  assign memWrite   = mem_write_q;
  assign memAddress = mem_address_q;
  assign memData    = mem_data_q;
  assign memWide    = mem_wide_q;
  assign run        = run_q;
  assign error      = error_q;
  assign cmdCount   = cmd_count_q;

endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader: command/data writes, bounds, bad tag, backpressure, reset.
module tb_program_loader;

  logic        clock;
  logic        resetN;
  logic [7:0]  inByte;
  logic        inValid;
  logic        inReady;
  logic        memWrite;
  logic [15:0] memAddress;
  logic [23:0] memData;
  logic        memWide;
  logic        run;
  logic        error;
  logic [15:0] cmdCount;

  int n_checks = 0;
  int n_pass   = 0;
  int wr_count = 0;
  int wr_base;

  program_loader dut (
    .clock      (clock),
    .resetN     (resetN),
    .inByte     (inByte),
    .inValid    (inValid),
    .inReady    (inReady),
    .memWrite   (memWrite),
    .memAddress (memAddress),
    .memData    (memData),
    .memWide    (memWide),
    .run        (run),
    .error      (error),
    .cmdCount   (cmdCount)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(negedge clock) begin
    if (resetN && memWrite) wr_count <= wr_count + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end else begin
      n_pass++;
    end
  endtask

  // Called just after a posedge or negedge; returns #1 after the accepting edge.
  task automatic send_byte(input logic [7:0] b, input int gap);
    int waited;
    inValid = 1'b0;
    repeat (gap) @(negedge clock);
    inByte  = b;
    inValid = 1'b1;
    waited  = 0;
    while (!inReady && waited < 20) begin
      @(negedge clock);
      waited++;
    end
    if (!inReady) begin
      check("ready_timeout", 32'(inReady), 32'd1);
      inValid = 1'b0;
    end else begin
      @(posedge clock);
      #1;
      inValid = 1'b0;
    end
  endtask

  task automatic send_cmd(input logic [7:0] op, input logic [15:0] a, input int gap);
    send_byte(8'hC0, gap);
    send_byte(op, gap);
    send_byte(a[15:8], gap);
    send_byte(a[7:0], gap);
  endtask

  task automatic send_data(input logic [15:0] a, input logic [15:0] d);
    send_byte(8'hD0, 0);
    send_byte(a[15:8], 0);
    send_byte(a[7:0], 0);
    send_byte(d[15:8], 0);
    send_byte(d[7:0], 0);
  endtask

  task automatic expect_write(input string tag, input logic [15:0] a, input logic [23:0] d,
                              input logic w, input logic [15:0] cnt);
    check({tag, "_strobe"}, 32'(memWrite), 32'd1);
    check({tag, "_rdy_lo"}, 32'(inReady), 32'd0);
    check({tag, "_addr"}, 32'(memAddress), 32'(a));
    check({tag, "_data"}, 32'(memData), 32'(d));
    check({tag, "_wide"}, 32'(memWide), 32'(w));
    @(posedge clock);
    #1;
    check({tag, "_strobe_off"}, 32'(memWrite), 32'd0);
    check({tag, "_rdy_hi"}, 32'(inReady), 32'd1);
    check({tag, "_addr_hold"}, 32'(memAddress), 32'(a));
    check({tag, "_count"}, 32'(cmdCount), 32'(cnt));
  endtask

  task automatic do_reset();
    @(negedge clock);
    inValid = 1'b0;
    resetN  = 1'b0;
    @(negedge clock);
    resetN  = 1'b1;
  endtask

  initial begin
    resetN  = 1'b1;
    inValid = 1'b0;
    inByte  = 8'h00;
    #2 resetN = 1'b0;
    #10;
    check("rst_ready", 32'(inReady), 32'd1);
    check("rst_we", 32'(memWrite), 32'd0);
    check("rst_addr", 32'(memAddress), 32'd0);
    check("rst_data", 32'(memData), 32'd0);
    check("rst_wide", 32'(memWide), 32'd0);
    check("rst_run", 32'(run), 32'd0);
    check("rst_err", 32'(error), 32'd0);
    check("rst_count", 32'(cmdCount), 32'd0);
    @(negedge clock);
    resetN = 1'b1;

    send_cmd(8'h00, 16'h01F4, 0);
    expect_write("cmd0", 16'd0, 24'h0001F4, 1'b1, 16'd1);
    send_cmd(8'h11, 16'h0204, 0);
    expect_write("cmd1", 16'd24, 24'h110204, 1'b1, 16'd2);
    send_data(16'h0204, 16'h0001);
    expect_write("data516", 16'd516, 24'h000100, 1'b0, 16'd2);
    send_cmd(8'h21, 16'h0010, 3);
    expect_write("gapcmd", 16'd48, 24'h210010, 1'b1, 16'd3);

    // Reset in the middle of a record.
    send_byte(8'hC0, 0);
    send_byte(8'h11, 0);
    #2 resetN = 1'b0;
    #1;
    check("midrst_count", 32'(cmdCount), 32'd0);
    check("midrst_ready", 32'(inReady), 32'd1);
    @(negedge clock);
    resetN = 1'b1;
    send_cmd(8'h00, 16'h01F4, 0);
    expect_write("postrst", 16'd0, 24'h0001F4, 1'b1, 16'd1);

    // Command bounds: index 41 is the last legal slot.
    do_reset();
    wr_base = wr_count;
    for (int i = 0; i < 41; i++) send_cmd(8'h00, 16'(i), 0);
    send_cmd(8'h25, 16'h0029, 0);
    expect_write("cmd41", 16'd984, 24'h250029, 1'b1, 16'd42);
    send_cmd(8'h31, 16'h002A, 0);
    check("cmd42_err", 32'(error), 32'd1);
    check("cmd42_we", 32'(memWrite), 32'd0);
    check("cmd42_count", 32'(cmdCount), 32'd42);
    check("cmd42_rdy", 32'(inReady), 32'd0);
    @(negedge clock);
    #1;
    check("cmd_total_writes", 32'(wr_count - wr_base), 32'd42);

    // Data bounds: 1009 fits, 1010 faults.
    do_reset();
    send_data(16'd1009, 16'hABCD);
    expect_write("data1009", 16'd1009, 24'hABCD00, 1'b0, 16'd0);
    wr_base = wr_count;
    send_data(16'd1010, 16'h1234);
    check("data1010_err", 32'(error), 32'd1);
    check("data1010_we", 32'(memWrite), 32'd0);
    @(negedge clock);
    #1;
    check("data1010_nowr", 32'(wr_count - wr_base), 32'd0);

    // Address near the top of the 16-bit range must not wrap into range.
    do_reset();
    send_data(16'hFFF8, 16'h5555);
    check("wrap_err", 32'(error), 32'd1);
    check("wrap_we", 32'(memWrite), 32'd0);

    // Bad tag locks up the loader.
    do_reset();
    send_byte(8'h55, 0);
    check("badtag_err", 32'(error), 32'd1);
    check("badtag_rdy", 32'(inReady), 32'd0);
    inByte  = 8'hC0;
    inValid = 1'b1;
    repeat (4) @(posedge clock);
    #1;
    check("badtag_stuck_rdy", 32'(inReady), 32'd0);
    check("badtag_run", 32'(run), 32'd0);
    inValid = 1'b0;

    // FFFFFF opcode is plain data; only the end tag releases run.
    do_reset();
    send_cmd(8'hFF, 16'hFFFF, 0);
    expect_write("opff", 16'd0, 24'hFFFFFF, 1'b1, 16'd1);
    check("opff_run", 32'(run), 32'd0);
    send_byte(8'hE0, 0);
    check("end_run", 32'(run), 32'd1);
    check("end_rdy", 32'(inReady), 32'd0);
    check("end_err", 32'(error), 32'd0);
    repeat (3) @(posedge clock);
    #1;
    check("end_hold", 32'(run), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/program_loader.md
Name: program_loader

Overview:
- Byte-stream program loader that writes the instruction memory; it is the writer side of the processor's command-fetch path.
- It accepts tagged records over a valid/ready byte interface and assembles 24-bit commands (opcode byte plus 16-bit address) and 16-bit data words.
- Assembled items are written into the bit-addressed 1025-bit memory through a dedicated write port.
- It holds the processor stopped (run low) until an end record arrives, then releases it.

Parameters:
- MEM_BITS, 1025, memory size in bits; legal bit addresses are 0..MEM_BITS-1.
- CMD_BITS, 24, command width; consecutive commands are placed at index*CMD_BITS.
- DATA_BITS, 16, data word width.
- TAG_CMD, 8'hC0, record tag: next 3 bytes are one command.
- TAG_DATA, 8'hD0, record tag: next 2 bytes are a bit address, then 2 bytes of data.
- TAG_END, 8'hE0, record tag: loading complete.

Ports:
- clock  in  1  rising-edge clock
- resetN  in  1  asynchronous active-low reset
- inByte  in  8  stream byte
- inValid  in  1  inByte is valid
- inReady  out  1  loader accepts a byte; a transfer occurs when inValid and inReady are both high on a rising edge
- memWrite  out  1  one-cycle write strobe
- memAddress  out  16  first bit address of the write
- memData  out  24  write data, MSB-aligned; bits [0:15] carry a data word
- memWide  out  1  1 = 24-bit command write, 0 = 16-bit data write
- run  out  1  processor enable, gates the command pointer's start
- error  out  1  sticky fault flag
- cmdCount  out  16  number of commands written

Behaviour:
- Reset, asynchronous and immediate: state IDLE, inReady=1, memWrite=0, memAddress=0, memData=0, memWide=0, run=0, error=0, cmdCount=0, partial record discarded.
- States: IDLE, CMD0, CMD1, CMD2, DADR0, DADR1, DDAT0, DDAT1, WRITE, DONE, ERROR.
- IDLE takes a tag byte:
  - TAG_CMD goes to CMD0.
  - TAG_DATA goes to DADR0.
  - TAG_END goes to DONE.
  - Any other value goes to ERROR.
- CMD0..CMD2 shift in opcode, address high byte, address low byte, in that order. The first byte received lands at the lowest bit address (memData[0:7] = opcode).
- DADR0/DADR1 capture the 16-bit bit address, high byte first. DDAT0/DDAT1 capture the data word, high byte first.
- Write timing:
  - The last byte of a record is accepted in cycle N.
  - In cycle N+1 the block is in WRITE: memWrite=1 for exactly one cycle, inReady=0, and memAddress, memData and memWide are valid.
  - In cycle N+2 the state is IDLE and inReady=1.
  - Outputs hold their last values while memWrite=0.
- Command address is cmdCount*CMD_BITS, computed in 16 bits. cmdCount increments in the WRITE cycle of a command only; data writes do not touch it.
- Range check, done on entering WRITE: if address + width - 1 > MEM_BITS-1 (width 24 or 16), go to ERROR, do not pulse memWrite, and do not increment cmdCount. The comparison is evaluated in 17 bits so that wrap-around is caught.
  - Highest legal command index is 41 (bits 984..1007). Index 42 (1008..1031) faults.
  - Highest legal data address is 1009.
- DONE: run=1, inReady=0, held until reset.
- ERROR: error=1, run=0, inReady=0, held until reset.
- Bytes that arrive while inReady=0 are not consumed; the source must hold them.
- inValid gaps between bytes of a record are legal and stall the state machine with no timeout.
- The loader treats an FFFFFF opcode as ordinary data; only TAG_END releases run.
- Reset asserted mid-record clears everything; the next record starts at command index 0.

Decomposition:
- Shared package contents:
  - tag constants TAG_CMD, TAG_DATA, TAG_END
  - state enumeration
  - CMD_BITS, DATA_BITS, MEM_BITS
  - opcode constants shared with the command decoder (8'h00, 11, 15, 21, 25, 31, F0, FE, FF)
- One sub-module: loader_assembler, a byte shift register that produces the 24/16-bit fields and the 16-bit address.
- The state machine, range check and counters stay in the top.

Test Plan:
- Command write: stream C0 00 01 F4 -> memWrite pulses one cycle later with memAddress=0, memData=0001F4, memWide=1, cmdCount=1. A second record C0 11 02 04 -> memAddress=24, cmdCount=2.
- Data write: stream D0 02 04 00 01 -> memAddress=516, memData[0:15]=0001, memWide=0, cmdCount unchanged.
- Full Fibonacci image: 15 command records and 3 data records, then E0 -> run=1, inReady=0. Memory dump matches the image, and the processor runs to a final register value of 987.
- Bounds: 42 command records -> the last written address is 984. The 43rd record gives error=1, no write pulse, cmdCount=42. Data record D0 03 F2 ... (1010) -> error=1, no write.
- Bad tag 55 -> error=1, inReady=0. Subsequent bytes are not accepted, and run stays 0.
- Backpressure and reset: 3-cycle inValid gaps inside a record still produce a correct write. Asserting resetN=0 after C0 11 clears state; the next record C0 00 01 F4 writes to address 0.
